vec_regfile_banked: RTL
=======================

// Module: vec_regfile_banked
// PURPOSE
//   Parametrised vector register file for the vector datapath: NREGS registers of LANES x ELEM_W bits.
//   Provides two registered read ports (decode stage) and one lane-masked write port (write-back).
//   Adds same-cycle write->read bypass, a pending-write scoreboard with read stall, and a bulk-clear FSM.
//   All logic runs on a single clock edge.
// PARAMETERS
//   LANES   4   number of vector elements per register
//   ELEM_W  8   bits per element; register width VW = LANES*ELEM_W
//   NREGS   8   number of vector registers (power of 2, >=2)
//   AW      3   address width, = $clog2(NREGS)
// PORTS
//   clk        in   1       clock; all state updates on posedge
//   rst        in   1       synchronous, active-high reset
//   rd_en      in   1       read request, both ports
//   rd_addr1   in   AW      read port 1 register index
//   rd_addr2   in   AW      read port 2 register index
//   rd_data1   out  VW      registered read data, port 1
//   rd_data2   out  VW      registered read data, port 2
//   rd_valid   out  1       rd_data1/2 updated this cycle
//   rd_stall   out  1       comb.: request not accepted this cycle
//   wr_en      in   1       write request
//   wr_addr    in   AW      write register index
//   wr_mask    in   LANES   per-lane write enable; lane i = bits [i*ELEM_W +: ELEM_W]
//   wr_data    in   VW      write data
//   resv_en    in   1       reserve register (mark pending write)
//   resv_addr  in   AW      register to reserve
//   clr_start  in   1       start bulk clear
//   clr_busy   out  1       bulk clear in progress
// BEHAVIOUR
//   Reset: mem[*]=0, pend[*]=0, rd_data1/2=0, rd_valid=0, FSM=IDLE, clr_busy=0. Reset mid-clear aborts.
//   Write (IDLE only): at posedge, if wr_en, lanes with wr_mask[i]=1 take wr_data; other lanes keep value.
//     wr_mask=0 updates no lane but still clears pend[wr_addr].
//   Read: latency 1. If rd_en & !rd_stall at posedge N, rd_data1/2 hold data at N+1 and rd_valid=1 at N+1.
//     Otherwise rd_valid=0 and rd_data1/2 hold their previous values.
//   Bypass: on a same-cycle wr_en with wr_addr==rd_addrX, masked lanes return wr_data and unmasked lanes return old mem.
//     Applies to each port independently, and to both ports when addr1==addr2.
//   Scoreboard: pend[NREGS]. resv_en sets pend[resv_addr]; wr_en clears pend[wr_addr].
//     Same-cycle resv_en and wr_en to the same addr: set wins (pend=1).
//     Effective pending: pend[a] & !(wr_en & wr_addr==a). A same-cycle write resolves the hazard via bypass.
//   rd_stall = rd_en & (state==CLEAR | eff_pend[rd_addr1] | eff_pend[rd_addr2]). Combinational; no input->stall dependency on rd_data.
//   FSM IDLE -> CLEAR: on clr_start in IDLE, idx<=0.
//     In CLEAR, each cycle mem[idx]<=0 and pend[idx]<=0, idx++.
//     After idx==NREGS-1 is cleared, next state is IDLE.
//     clr_busy=1 exactly NREGS cycles; clr_start while in CLEAR is ignored.
//   In CLEAR: wr_en and resv_en are ignored (dropped, not queued); reads stall.
//   Priority at the same posedge: rst > CLEAR activity > write/reserve > read.
// TESTING
//   T1 Reset then read all regs (no writes) -> rd_data1/2=0 and rd_valid=1 one cycle after each rd_en; rd_stall=0.
//   T2 Write r3=0xDEADBEEF, mask=4'b1111; next cycle wr r3 data 0x11223344 mask 4'b0101; read r3
//      -> rd_data1=0xDE22BE44.
//   T3 Same cycle: wr r5=0xA5A5A5A5 mask 4'b1111, rd_addr1=5, rd_addr2=5 (r5 was 0)
//      -> next cycle both ports = 0xA5A5A5A5, rd_valid=1.
//   T4 resv r2; read r2 next cycle -> rd_stall=1, rd_valid=0 next cycle.
//      Then wr r2=0x01020304 with rd r2 in the same cycle -> no stall, data 0x01020304.
//      Resv+wr r6 in the same cycle -> pend[6]=1.
//   T5 Fill r0..r7 with nonzero values; pulse clr_start -> clr_busy=1 for 8 cycles.
//      Writes and reads issued during clear are dropped or stalled; afterwards all regs and pend read 0.
//   T6 Assert rst at the 4th cycle of a clear -> next cycle clr_busy=0, FSM IDLE, all regs 0,
//      rd_data1/2=0, rd_valid=0.

Source files
------------

// File: rtl/vec_regfile_banked_if.sv
// vec_regfile_banked_if
//   Groups the read, write, reserve and clear signals of the vector register file.
//   The register file uses the slave modport. A driver (decode/write-back logic or a bench)
//   uses the master modport.
// Signals
//   rd_en, rd_addr1, rd_addr2       read request and the two register indices
//   rd_data1, rd_data2, rd_valid    registered read results
//   rd_stall                        combinational: the read request is not accepted this cycle
//   wr_en, wr_addr, wr_mask, wr_data    lane-masked write
//   resv_en, resv_addr              mark a register as having a pending write
//   clr_start, clr_busy             bulk-clear start and busy indication
interface vec_regfile_banked_if #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 8,
    parameter int NREGS  = 8,
    parameter int AW     = 3
);
    localparam int VW = LANES * ELEM_W;

    logic              rd_en;
    logic [AW-1:0]     rd_addr1;
    logic [AW-1:0]     rd_addr2;
    logic [VW-1:0]     rd_data1;
    logic [VW-1:0]     rd_data2;
    logic              rd_valid;
    logic              rd_stall;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [LANES-1:0]  wr_mask;
    logic [VW-1:0]     wr_data;
    logic              resv_en;
    logic [AW-1:0]     resv_addr;
    logic              clr_start;
    logic              clr_busy;

    modport master (
        output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_mask, wr_data,
               resv_en, resv_addr, clr_start,
        input  rd_data1, rd_data2, rd_valid, rd_stall, clr_busy
    );

    modport slave (
        input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_mask, wr_data,
               resv_en, resv_addr, clr_start,
        output rd_data1, rd_data2, rd_valid, rd_stall, clr_busy
    );
endinterface

// File: rtl/vec_regfile_banked.sv
// vec_regfile_banked
//   Vector register file with NREGS registers of LANES x ELEM_W bits.
//   It provides two registered read ports and one lane-masked write port. A read that names the
//   register being written in the same cycle sees the write data on the masked lanes (bypass).
//   A pending-write scoreboard stalls reads of reserved registers. A bulk-clear FSM zeroes one
//   register per cycle.
// Ports
//   clk   clock; all state changes on the rising edge
//   rst   synchronous, active-high reset
//   bus   vec_regfile_banked_if.slave (read/write/reserve/clear signals)
module vec_regfile_banked #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 8,
    parameter int NREGS  = 8,
    parameter int AW     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    vec_regfile_banked_if.slave   bus
);
    localparam int VW = LANES * ELEM_W;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clrIdx_q, clrIdx_d;
    logic [VW-1:0]   mem_q [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [VW-1:0]   rdData1_q, rdData2_q;
    logic            rdValid_q;

    logic            clearing;
    logic            wrAct;
    logic            resvAct;
    logic            rdStall;
    logic            rdAccept;
    logic [NREGS-1:0] effPend;
    logic [VW-1:0]   laneMask;
    logic [VW-1:0]   wrMerged;
    logic [VW-1:0]   rdNext1;
    logic [VW-1:0]   rdNext2;

    // Expand the per-lane write mask to a bit mask. Merge the write data into the current
    // contents of the target register. The merged word feeds both the array and the bypass path.
    always_comb begin
        laneMask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.wr_mask[i]) begin
                laneMask[i*ELEM_W +: ELEM_W] = '1;
            end
        end
        wrMerged = (mem_q[bus.wr_addr] & ~laneMask) | (bus.wr_data & laneMask);
    end

    // Writes and reservations count only outside a bulk clear. During a clear they are dropped.
    // A write in this cycle resolves its register's hazard, because the bypass delivers the new
    // data to the reader.
    always_comb begin
        clearing = (state_q == CLEAR);
        wrAct    = bus.wr_en & ~clearing;
        resvAct  = bus.resv_en & ~clearing;
        effPend  = pend_q;
        if (wrAct) begin
            effPend[bus.wr_addr] = 1'b0;
        end
        rdStall  = bus.rd_en & (clearing | effPend[bus.rd_addr1] | effPend[bus.rd_addr2]);
        rdAccept = bus.rd_en & ~rdStall;
    end

    // Read data for the next cycle. If a port addresses the register being written now, it
    // takes the merged word. The merged word has the write data on masked lanes and the old
    // contents elsewhere.
    always_comb begin
        rdNext1 = mem_q[bus.rd_addr1];
        rdNext2 = mem_q[bus.rd_addr2];
        if (wrAct && (bus.wr_addr == bus.rd_addr1)) begin
            rdNext1 = wrMerged;
        end
        if (wrAct && (bus.wr_addr == bus.rd_addr2)) begin
            rdNext2 = wrMerged;
        end
    end

    // Bulk-clear sequencing. clr_start in IDLE starts a sweep at register 0. The FSM stays in
    // CLEAR for exactly NREGS cycles and then returns to IDLE. clr_start during CLEAR has no effect.
    always_comb begin
        state_d  = state_q;
        clrIdx_d = clrIdx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    state_d  = CLEAR;
                    clrIdx_d = '0;
                end
            end
            CLEAR: begin
                clrIdx_d = clrIdx_q + 1'b1;
                if (clrIdx_q == AW'(NREGS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state updates. Reset comes first. A clear in progress owns the array and scoreboard.
    // Otherwise writes and reservations apply. If a reservation and a write hit the same
    // register in one cycle, the later assignment sets the flag, so the reservation wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clrIdx_q  <= '0;
            pend_q    <= '0;
            rdData1_q <= '0;
            rdData2_q <= '0;
            rdValid_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clrIdx_q  <= clrIdx_d;
            rdValid_q <= rdAccept;
            if (rdAccept) begin
                rdData1_q <= rdNext1;
                rdData2_q <= rdNext2;
            end
            if (clearing) begin
                mem_q[clrIdx_q]  <= '0;
                pend_q[clrIdx_q] <= 1'b0;
            end else begin
                if (wrAct) begin
                    mem_q[bus.wr_addr]  <= wrMerged;
                    pend_q[bus.wr_addr] <= 1'b0;
                end
                if (resvAct) begin
                    pend_q[bus.resv_addr] <= 1'b1;
                end
            end
        end
    end

    assign bus.rd_data1 = rdData1_q;
    assign bus.rd_data2 = rdData2_q;
    assign bus.rd_valid = rdValid_q;
    assign bus.rd_stall = rdStall;
    assign bus.clr_busy = clearing;

endmodule
